// File: rtl/console_msg_buffer.sv
// Byte FIFO between the FIX engine output stream and the console slave bus, plus a one-deep CONN command latch.
// Optional EOM statistics counter at 0x03/0x04 is enabled by defining CONSOLE_MSG_BUFFER_STATS_EN.
module console_msg_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] slave_address,
  input  logic       slave_read,
  output logic [7:0] slave_readdata,
  input  logic       slave_write,
  input  logic [7:0] slave_writedata,
  input  logic       msg_valid,
  input  logic [7:0] msg_data,
  input  logic       msg_eom,
  output logic       msg_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   mcount;
  logic          cmd_overrun, underflow, last_eom;
  logic [8:0]    head;
  logic          full, empty, read_en, push, pop, flush, clear_sticky, conn_wr;
  logic [7:0]    status, mcount_sat, rd_value;

  assign head      = mem[rd_ptr];
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign msg_ready = ~full;

  // A simultaneous write wins over a read, so the read path is gated here.
  assign read_en      = slave_read & ~slave_write;
  assign flush        = slave_write && (slave_address == 8'h07) && slave_writedata[0];
  assign clear_sticky = slave_write && (slave_address == 8'h07) && slave_writedata[1];
  assign conn_wr      = slave_write && (slave_address == 8'h06);
  assign push         = msg_valid & msg_ready & ~flush;
  assign pop          = read_en && (slave_address == 8'h01) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {msg_eom, msg_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mcount   <= '0;
      last_eom <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mcount   <= '0;
      last_eom <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_eom <= head[8];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({push & msg_eom, pop & head[8]})
        2'b10:   mcount <= mcount + 1'b1;
        2'b01:   mcount <= mcount - 1'b1;
        default: mcount <= mcount;
      endcase
    end
  end

  // A CONN write that lands while a command is still pending (even in its consume cycle) is an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd_data    <= 8'h00;
      cmd_overrun <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (conn_wr && !cmd_valid) begin
        cmd_valid <= 1'b1;
        cmd_data  <= slave_writedata;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (clear_sticky) begin
        cmd_overrun <= 1'b0;
        underflow   <= 1'b0;
      end else begin
        if (conn_wr && cmd_valid) cmd_overrun <= 1'b1;
        if (read_en && (slave_address == 8'h01) && empty) underflow <= 1'b1;
      end
    end
  end

`ifdef CONSOLE_MSG_BUFFER_STATS_EN
  logic [15:0] stats_cnt;
  logic [7:0]  stats_snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stats_cnt  <= 16'h0000;
      stats_snap <= 8'h00;
    end else begin
      if (push && msg_eom) stats_cnt <= stats_cnt + 16'h0001;
      if (read_en && (slave_address == 8'h03)) stats_snap <= stats_cnt[15:8];
    end
  end
`endif

  assign status     = {1'b0, last_eom, !empty, underflow, cmd_overrun, cmd_valid, full, (mcount != '0)};
  assign mcount_sat = (32'(mcount) > 32'd255) ? 8'hFF : 8'(mcount);

  always_comb begin
    rd_value = 8'h00;
    case (slave_address)
      8'h00:   rd_value = status;
      8'h01:   rd_value = empty ? 8'h00 : head[7:0];
      8'h02:   rd_value = mcount_sat;
`ifdef CONSOLE_MSG_BUFFER_STATS_EN
      8'h03:   rd_value = stats_cnt[7:0];
      8'h04:   rd_value = stats_snap;
`endif
      default: rd_value = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        slave_readdata <= 8'h00;
    else if (read_en) slave_readdata <= rd_value;
  end

endmodule

// File: tb/tb_console_msg_buffer.sv
// Directed testbench for console_msg_buffer: bus accesses, message FIFO, CONN handshake, flush and stats.
module tb_console_msg_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] slave_address = 8'h00;
  logic       slave_read = 1'b0;
  logic [7:0] slave_readdata;
  logic       slave_write = 1'b0;
  logic [7:0] slave_writedata = 8'h00;
  logic       msg_valid = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_eom = 1'b0;
  logic       msg_ready;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready = 1'b0;

  int checks = 0;
  int passed = 0;

  console_msg_buffer dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_eom(msg_eom), .msg_ready(msg_ready),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    slave_address = addr;
    slave_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    slave_read = 1'b0;
    data = slave_readdata;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    slave_address   = addr;
    slave_writedata = data;
    slave_write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] data, input logic eom);
    msg_valid = 1'b1;
    msg_data  = data;
    msg_eom   = eom;
    @(posedge clk);
    @(negedge clk);
    msg_valid = 1'b0;
    msg_eom   = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    do_reset();
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b1);
    bus_write(8'h06, 8'h5A);
    do_reset();
    checks++;
    if (slave_readdata !== 8'h00) $display("[TB] FAIL reset_readdata: got %h expected 00", slave_readdata);
    else passed++;
    checks++;
    if (msg_ready !== 1'b1) $display("[TB] FAIL reset_msg_ready: got %b expected 1", msg_ready);
    else passed++;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 8'h00)
      $display("[TB] FAIL reset_cmd: got valid=%b data=%h expected valid=0 data=00", cmd_valid, cmd_data);
    else passed++;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL reset_status: got %h expected 00", rd);
    else passed++;
  endtask

  task automatic test_message();
    logic [7:0] rd;
    do_reset();
    for (int i = 0; i < 199; i++) push_byte(8'(i) ^ 8'h5A, (i == 198));
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h21) $display("[TB] FAIL msg_status_loaded: got %h expected 21", rd);
    else passed++;
    bus_read(8'h02, rd);
    checks++;
    if (rd !== 8'h01) $display("[TB] FAIL msg_mcount_loaded: got %h expected 01", rd);
    else passed++;
    for (int i = 0; i < 199; i++) begin
      bus_read(8'h01, rd);
      checks++;
      if (rd !== (8'(i) ^ 8'h5A)) $display("[TB] FAIL msg_rdata[%0d]: got %h expected %h", i, rd, 8'(i) ^ 8'h5A);
      else passed++;
    end
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h40) $display("[TB] FAIL msg_status_drained: got %h expected 40", rd);
    else passed++;
    bus_read(8'h02, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL msg_mcount_drained: got %h expected 00", rd);
    else passed++;
  endtask

  task automatic test_cmd();
    logic [7:0] rd;
    do_reset();
    cmd_ready = 1'b0;
    bus_write(8'h06, 8'hBB);
    bus_write(8'h06, 8'hCC);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'hBB)
      $display("[TB] FAIL cmd_hold: got valid=%b data=%h expected valid=1 data=BB", cmd_valid, cmd_data);
    else passed++;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h0C) $display("[TB] FAIL cmd_status_overrun: got %h expected 0C", rd);
    else passed++;
    cmd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) $display("[TB] FAIL cmd_consumed: got %b expected 0", cmd_valid);
    else passed++;
    bus_write(8'h07, 8'h02);
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL cmd_sticky_cleared: got %h expected 00", rd);
    else passed++;
    // CONN write in the consume cycle counts as overrun, not a reload
    bus_write(8'h06, 8'h11);
    cmd_ready = 1'b1;
    bus_write(8'h06, 8'h22);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 8'h11)
      $display("[TB] FAIL cmd_same_cycle: got valid=%b data=%h expected valid=0 data=11", cmd_valid, cmd_data);
    else passed++;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h08) $display("[TB] FAIL cmd_same_cycle_status: got %h expected 08", rd);
    else passed++;
  endtask

  task automatic test_full();
    logic [7:0] rd;
    do_reset();
    for (int i = 0; i < 256; i++) push_byte(8'(i), 1'b0);
    checks++;
    if (msg_ready !== 1'b0) $display("[TB] FAIL full_msg_ready: got %b expected 0", msg_ready);
    else passed++;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h22) $display("[TB] FAIL full_status: got %h expected 22", rd);
    else passed++;
    // Engine keeps offering a byte while full; the concurrent pop must not let it in
    msg_valid = 1'b1;
    msg_data  = 8'hEE;
    bus_read(8'h01, rd);
    msg_valid = 1'b0;
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL full_first_pop: got %h expected 00", rd);
    else passed++;
    checks++;
    if (msg_ready !== 1'b1) $display("[TB] FAIL full_ready_after_pop: got %b expected 1", msg_ready);
    else passed++;
    for (int i = 1; i < 256; i++) begin
      bus_read(8'h01, rd);
      checks++;
      if (rd !== 8'(i)) $display("[TB] FAIL full_drain[%0d]: got %h expected %h", i, rd, 8'(i));
      else passed++;
    end
    bus_read(8'h01, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL empty_read: got %h expected 00", rd);
    else passed++;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h10) $display("[TB] FAIL empty_underflow_status: got %h expected 10", rd);
    else passed++;
  endtask

  task automatic test_flush();
    logic [7:0] rd;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      push_byte(8'h30 + 8'(m), 1'b0);
      push_byte(8'h40 + 8'(m), 1'b1);
    end
    bus_read(8'h02, rd);
    checks++;
    if (rd !== 8'h03) $display("[TB] FAIL flush_mcount_before: got %h expected 03", rd);
    else passed++;
    msg_valid = 1'b1;
    msg_data  = 8'h77;
    msg_eom   = 1'b1;
    bus_write(8'h07, 8'h01);
    msg_valid = 1'b0;
    msg_eom   = 1'b0;
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL flush_status: got %h expected 00", rd);
    else passed++;
    bus_read(8'h02, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL flush_mcount: got %h expected 00", rd);
    else passed++;
    bus_read(8'h01, rd);
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h10) $display("[TB] FAIL flush_discarded_push: got %h expected 10", rd);
    else passed++;
  endtask

  task automatic test_read_write_conflict();
    logic [7:0] rd;
    do_reset();
    push_byte(8'h99, 1'b1);
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 8'h21) $display("[TB] FAIL conflict_status: got %h expected 21", rd);
    else passed++;
    slave_read = 1'b1;
    bus_write(8'h06, 8'h33);
    slave_read = 1'b0;
    checks++;
    if (slave_readdata !== 8'h21) $display("[TB] FAIL conflict_readdata_hold: got %h expected 21", slave_readdata);
    else passed++;
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h33)
      $display("[TB] FAIL conflict_write: got valid=%b data=%h expected valid=1 data=33", cmd_valid, cmd_data);
    else passed++;
    bus_read(8'h05, rd);
    checks++;
    if (rd !== 8'h00) $display("[TB] FAIL unmapped_read: got %h expected 00", rd);
    else passed++;
  endtask

  task automatic test_stats();
    logic [7:0] rd;
    logic [7:0] exp_lo, exp_hi;
    do_reset();
`ifdef CONSOLE_MSG_BUFFER_STATS_EN
    exp_lo = 8'h2C;
    exp_hi = 8'h01;
`else
    exp_lo = 8'h00;
    exp_hi = 8'h00;
`endif
    for (int i = 0; i < 200; i++) push_byte(8'(i), 1'b1);
    bus_write(8'h07, 8'h01);
    for (int i = 0; i < 100; i++) push_byte(8'(i), 1'b1);
    bus_read(8'h03, rd);
    checks++;
    if (rd !== exp_lo) $display("[TB] FAIL stats_low: got %h expected %h", rd, exp_lo);
    else passed++;
    push_byte(8'hAB, 1'b1);
    bus_read(8'h04, rd);
    checks++;
    if (rd !== exp_hi) $display("[TB] FAIL stats_high_snapshot: got %h expected %h", rd, exp_hi);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_message();
    test_cmd();
    test_full();
    test_flush();
    test_read_write_conflict();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
